// File: rtl/hazard_pipe_tracker_if.sv
// Signal bundle between the hazard unit / D stage and the pipeline tracker.
// The master drives the D-stage descriptor and stall; the slave returns per-stage fields.
interface hazard_pipe_tracker_if #(
  parameter int STALL_CNT_W  = 32,
  parameter int RETIRE_CNT_W = 32
);
  logic                    stall;
  logic                    d_valid;
  logic [4:0]              d_rs;
  logic [4:0]              d_rt;
  logic [4:0]              d_write_reg;
  logic                    d_write_enable;
  logic                    d_mem_to_reg;

  logic                    fd_enable;

  logic                    e_valid;
  logic [4:0]              e_rs;
  logic [4:0]              e_rt;
  logic [4:0]              e_write_reg;
  logic                    e_write_enable;
  logic                    e_mem_to_reg;

  logic                    m_valid;
  logic [4:0]              m_rs;
  logic [4:0]              m_rt;
  logic [4:0]              m_write_reg;
  logic                    m_write_enable;
  logic                    m_mem_to_reg;

  logic                    w_valid;
  logic [4:0]              w_write_reg;
  logic                    w_write_enable;

  logic [STALL_CNT_W-1:0]  stall_cycles;
  logic [RETIRE_CNT_W-1:0] retired;

  modport master (
    output stall, d_valid, d_rs, d_rt, d_write_reg, d_write_enable, d_mem_to_reg,
    input  fd_enable,
    input  e_valid, e_rs, e_rt, e_write_reg, e_write_enable, e_mem_to_reg,
    input  m_valid, m_rs, m_rt, m_write_reg, m_write_enable, m_mem_to_reg,
    input  w_valid, w_write_reg, w_write_enable,
    input  stall_cycles, retired
  );

  modport slave (
    input  stall, d_valid, d_rs, d_rt, d_write_reg, d_write_enable, d_mem_to_reg,
    output fd_enable,
    output e_valid, e_rs, e_rt, e_write_reg, e_write_enable, e_mem_to_reg,
    output m_valid, m_rs, m_rt, m_write_reg, m_write_enable, m_mem_to_reg,
    output w_valid, w_write_reg, w_write_enable,
    output stall_cycles, retired
  );
endinterface

// File: rtl/hazard_pipe_tracker.sv
// Carries D-stage register-usage descriptors through E/M/W for the hazard unit,
// inserts bubbles into E on stall, and keeps saturating stall/retire counters.
module hazard_pipe_tracker #(
  parameter int STALL_CNT_W  = 32,
  parameter int RETIRE_CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hazard_pipe_tracker_if.slave  bus
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] write_reg;
    logic       write_enable;
    logic       mem_to_reg;
  } stage_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] write_reg;
    logic       write_enable;
  } wb_stage_t;

  stage_t                  r_e;
  stage_t                  r_m;
  wb_stage_t               r_w;
  logic [STALL_CNT_W-1:0]  r_stall_cycles;
  logic [RETIRE_CNT_W-1:0] r_retired;

  stage_t                  w_d_cap;
  logic                    w_d_we;

  // A stall or an empty D slot both become an all-zero bubble; $0 never reports a write.
  always_comb begin
    w_d_cap = '0;
    w_d_we  = bus.d_valid & bus.d_write_enable & (bus.d_write_reg != 5'd0);
    if (bus.d_valid && !bus.stall) begin
      w_d_cap.valid        = 1'b1;
      w_d_cap.rs           = bus.d_rs;
      w_d_cap.rt           = bus.d_rt;
      w_d_cap.write_reg    = bus.d_write_reg;
      w_d_cap.write_enable = w_d_we;
      w_d_cap.mem_to_reg   = bus.d_mem_to_reg & w_d_we;
    end
  end

  // NOTE: non-blocking assignments let every stage sample the previous stage's old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e            <= '0;
      r_m            <= '0;
      r_w            <= '0;
      r_stall_cycles <= '0;
      r_retired      <= '0;
    end else begin
      r_e               <= w_d_cap;
      r_m               <= r_e;
      r_w.valid         <= r_m.valid;
      r_w.write_reg     <= r_m.write_reg;
      r_w.write_enable  <= r_m.write_enable;
      if (bus.stall && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
      if (r_w.valid && (r_retired != '1)) begin
        r_retired <= r_retired + 1'b1;
      end
    end
  end

  // Unregistered so IF/ID freezes in the same cycle the hazard unit raises stall.
  assign bus.fd_enable      = ~bus.stall;

  assign bus.e_valid        = r_e.valid;
  assign bus.e_rs           = r_e.rs;
  assign bus.e_rt           = r_e.rt;
  assign bus.e_write_reg    = r_e.write_reg;
  assign bus.e_write_enable = r_e.write_enable;
  assign bus.e_mem_to_reg   = r_e.mem_to_reg;

  assign bus.m_valid        = r_m.valid;
  assign bus.m_rs           = r_m.rs;
  assign bus.m_rt           = r_m.rt;
  assign bus.m_write_reg    = r_m.write_reg;
  assign bus.m_write_enable = r_m.write_enable;
  assign bus.m_mem_to_reg   = r_m.mem_to_reg;

  assign bus.w_valid        = r_w.valid;
  assign bus.w_write_reg    = r_w.write_reg;
  assign bus.w_write_enable = r_w.write_enable;

  assign bus.stall_cycles   = r_stall_cycles;
  assign bus.retired        = r_retired;

endmodule
